// File: rtl/spi_reg_ctrl.sv
// SPI slave command/register sequencer: decodes command + burst per frame, drives
// register bank write/read strobes with address auto-increment and feeds MISO bytes.
module spi_reg_ctrl #(
  parameter logic [6:0] RO_BASE = 7'h60
) (
  input  logic       reset,
  input  logic       S_CLK,
  input  logic       i_ss,
  input  logic       i_rx_dv,
  input  logic [7:0] i_rx_data,
  output logic [7:0] o_tx_data,
  output logic       o_tx_dv,
  output logic [6:0] o_reg_addr,
  output logic [7:0] o_reg_wdata,
  output logic       o_reg_we,
  output logic       o_reg_re,
  input  logic [7:0] i_reg_rdata,
  input  logic       i_err_clr,
  output logic       o_busy,
  output logic       o_err
);

  typedef enum logic [2:0] {
    S_CMD      = 3'd0,
    S_WR       = 3'd1,
    S_RD_FETCH = 3'd2,
    S_RD_LOAD  = 3'd3,
    S_RD       = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_we;
  logic       r_re;
  logic       r_tx_dv;
  logic       r_busy;
  logic       r_wr_inc;
  logic       r_err;
  logic [6:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_tx_data;

  logic w_we_nxt;
  logic w_re_nxt;
  logic w_tx_dv_nxt;
  logic w_wr_inc_nxt;
  logic w_err_set;
  logic w_addr_load;
  logic w_wdata_load;
  logic w_addr_inc;

  // Next-state and strobe decode
  always_comb begin
    w_state_nxt  = r_state;
    w_we_nxt     = 1'b0;
    w_re_nxt     = 1'b0;
    w_tx_dv_nxt  = 1'b0;
    w_wr_inc_nxt = 1'b0;
    w_err_set    = 1'b0;
    w_addr_load  = 1'b0;
    w_wdata_load = 1'b0;
    if (i_ss) begin
      w_state_nxt = S_CMD;
    end else begin
      case (r_state)
        S_CMD: begin
          if (i_rx_dv) begin
            w_addr_load = 1'b1;
            if (i_rx_data[7]) begin
              w_state_nxt = S_RD_FETCH;
              w_re_nxt    = 1'b1;
            end else begin
              w_state_nxt = S_WR;
            end
          end else begin
            w_state_nxt = S_CMD;
          end
        end
        S_WR: begin
          if (i_rx_dv) begin
            w_wr_inc_nxt = 1'b1;
            if (r_addr < RO_BASE) begin
              w_we_nxt     = 1'b1;
              w_wdata_load = 1'b1;
            end else begin
              w_err_set = 1'b1;
            end
          end else begin
            w_wr_inc_nxt = 1'b0;
          end
        end
        S_RD_FETCH: begin
          w_state_nxt = S_RD_LOAD;
          w_tx_dv_nxt = 1'b1;
          w_err_set   = i_rx_dv;
        end
        S_RD_LOAD: begin
          w_state_nxt = S_RD;
          w_err_set   = i_rx_dv;
        end
        S_RD: begin
          if (i_rx_dv) begin
            w_state_nxt = S_RD_FETCH;
            w_re_nxt    = 1'b1;
          end else begin
            w_state_nxt = S_RD;
          end
        end
        default: begin
          w_state_nxt = S_CMD;
        end
      endcase
    end
  end

  // A write advances the address once its strobe cycle is over; a read advances it in LOAD
  assign w_addr_inc = r_wr_inc | (r_state == S_RD_LOAD);

  // FSM state and strobes; slave-select high aborts the frame asynchronously
  always_ff @(posedge S_CLK or negedge reset or posedge i_ss) begin
    if (!reset) begin
      r_state  <= S_CMD;
      r_we     <= 1'b0;
      r_re     <= 1'b0;
      r_tx_dv  <= 1'b0;
      r_busy   <= 1'b0;
      r_wr_inc <= 1'b0;
    end else if (i_ss) begin
      r_state  <= S_CMD;
      r_we     <= 1'b0;
      r_re     <= 1'b0;
      r_tx_dv  <= 1'b0;
      r_busy   <= 1'b0;
      r_wr_inc <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_we     <= w_we_nxt;
      r_re     <= w_re_nxt;
      r_tx_dv  <= w_tx_dv_nxt;
      r_busy   <= (w_state_nxt != S_CMD);
      r_wr_inc <= w_wr_inc_nxt;
    end
  end

  // Address, write data and transmit byte survive a frame abort
  always_ff @(posedge S_CLK or negedge reset) begin
    if (!reset) begin
      r_addr    <= 7'h00;
      r_wdata   <= 8'h00;
      r_tx_data <= 8'h00;
    end else begin
      if (w_addr_load) begin
        r_addr <= i_rx_data[6:0];
      end else if (w_addr_inc) begin
        r_addr <= r_addr + 7'd1;
      end else begin
        r_addr <= r_addr;
      end
      if (w_wdata_load) begin
        r_wdata <= i_rx_data;
      end else begin
        r_wdata <= r_wdata;
      end
      if (r_state == S_RD_FETCH) begin
        r_tx_data <= i_reg_rdata;
      end else begin
        r_tx_data <= r_tx_data;
      end
    end
  end

  // Sticky error flag, set has priority over clear
  always_ff @(posedge S_CLK or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end else if (i_err_clr) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err;
    end
  end

  assign o_tx_data   = r_tx_data;
  assign o_tx_dv     = r_tx_dv;
  assign o_reg_addr  = r_addr;
  assign o_reg_wdata = r_wdata;
  assign o_reg_we    = r_we;
  assign o_reg_re    = r_re;
  assign o_busy      = r_busy;
  assign o_err       = r_err;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: table of frames with hand-computed strobes,
// plus sequences for abort, dropped bytes, set-wins error and reset mid-read.
module tb_spi_reg_ctrl;

  logic       reset;
  logic       S_CLK;
  logic       i_ss;
  logic       i_rx_dv;
  logic [7:0] i_rx_data;
  logic [7:0] o_tx_data;
  logic       o_tx_dv;
  logic [6:0] o_reg_addr;
  logic [7:0] o_reg_wdata;
  logic       o_reg_we;
  logic       o_reg_re;
  logic [7:0] i_reg_rdata;
  logic       i_err_clr;
  logic       o_busy;
  logic       o_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] bank [128];

  spi_reg_ctrl dut (
    .reset       (reset),
    .S_CLK       (S_CLK),
    .i_ss        (i_ss),
    .i_rx_dv     (i_rx_dv),
    .i_rx_data   (i_rx_data),
    .o_tx_data   (o_tx_data),
    .o_tx_dv     (o_tx_dv),
    .o_reg_addr  (o_reg_addr),
    .o_reg_wdata (o_reg_wdata),
    .o_reg_we    (o_reg_we),
    .o_reg_re    (o_reg_re),
    .i_reg_rdata (i_reg_rdata),
    .i_err_clr   (i_err_clr),
    .o_busy      (o_busy),
    .o_err       (o_err)
  );

  initial S_CLK = 1'b0;
  always #5 S_CLK = ~S_CLK;

  // Register bank model: combinational read, clocked write, known contents on reset
  assign i_reg_rdata = bank[o_reg_addr];
  always @(posedge S_CLK) begin
    if (!reset) begin
      for (int i = 0; i < 128; i++) bank[i] <= 8'h00;
      bank[7'h20] <= 8'h5A;
      bank[7'h21] <= 8'h3C;
      bank[7'h22] <= 8'h99;
      bank[7'h7F] <= 8'h77;
      bank[7'h00] <= 8'h11;
      bank[7'h01] <= 8'h22;
    end else if (o_reg_we) begin
      bank[o_reg_addr] <= o_reg_wdata;
    end
  end

  typedef struct packed {
    logic [7:0]       cmd;
    logic [1:0]       n;
    logic [0:2][7:0]  din;
    logic [0:3][6:0]  addr;
    logic [0:3][7:0]  dexp;
    logic [0:2]       wexp;
    logic             err;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge S_CLK);
    chk("strobe_overlap", {31'd0, ({1'b0, o_reg_we} + {1'b0, o_reg_re} + {1'b0, o_tx_dv}) > 2'd1}, 32'd0);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic drive_byte(input logic [7:0] b);
    i_rx_data = b;
    i_rx_dv   = 1'b1;
    tick();
    i_rx_dv   = 1'b0;
  endtask

  initial begin
    vecs[0] = '{cmd:8'h10, n:2'd3, din:{8'hAA, 8'hBB, 8'hCC}, addr:{7'h10, 7'h11, 7'h12, 7'h00},
                dexp:{8'h00, 8'h00, 8'h00, 8'h00}, wexp:3'b111, err:1'b0};
    vecs[1] = '{cmd:8'hA0, n:2'd2, din:{8'h00, 8'h00, 8'h00}, addr:{7'h20, 7'h21, 7'h22, 7'h00},
                dexp:{8'h5A, 8'h3C, 8'h99, 8'h00}, wexp:3'b000, err:1'b0};
    vecs[2] = '{cmd:8'h5F, n:2'd2, din:{8'h01, 8'h02, 8'h00}, addr:{7'h5F, 7'h60, 7'h00, 7'h00},
                dexp:{8'h00, 8'h00, 8'h00, 8'h00}, wexp:3'b100, err:1'b1};
    vecs[3] = '{cmd:8'hFF, n:2'd2, din:{8'h00, 8'h00, 8'h00}, addr:{7'h7F, 7'h00, 7'h01, 7'h00},
                dexp:{8'h77, 8'h11, 8'h22, 8'h00}, wexp:3'b000, err:1'b0};
    vecs[4] = '{cmd:8'h90, n:2'd1, din:{8'h00, 8'h00, 8'h00}, addr:{7'h10, 7'h11, 7'h00, 7'h00},
                dexp:{8'hAA, 8'hBB, 8'h00, 8'h00}, wexp:3'b000, err:1'b0};
    vecs[5] = '{cmd:8'hDF, n:2'd1, din:{8'h00, 8'h00, 8'h00}, addr:{7'h5F, 7'h60, 7'h00, 7'h00},
                dexp:{8'h01, 8'h00, 8'h00, 8'h00}, wexp:3'b000, err:1'b0};

    reset = 1'b0; i_ss = 1'b1; i_rx_dv = 1'b0; i_rx_data = 8'h00; i_err_clr = 1'b0;
    repeat (3) @(negedge S_CLK);
    chk("rst_tx_data", {24'd0, o_tx_data}, 32'h00);
    chk("rst_addr", {25'd0, o_reg_addr}, 32'h00);
    chk("rst_wdata", {24'd0, o_reg_wdata}, 32'h00);
    chk("rst_strobes", {29'd0, o_reg_we, o_reg_re, o_tx_dv}, 32'd0);
    chk("rst_busy_err", {30'd0, o_busy, o_err}, 32'd0);
    reset = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      i_ss = 1'b0;
      idle(2);
      drive_byte(vecs[v].cmd);
      chk("busy_after_cmd", {31'd0, o_busy}, 32'd1);
      if (vecs[v].cmd[7]) begin
        chk("rd_re_cmd", {31'd0, o_reg_re}, 32'd1);
        chk("rd_addr_cmd", {25'd0, o_reg_addr}, {25'd0, vecs[v].addr[0]});
        tick();
        chk("rd_txdv_cmd", {31'd0, o_tx_dv}, 32'd1);
        chk("rd_txdata_cmd", {24'd0, o_tx_data}, {24'd0, vecs[v].dexp[0]});
        idle(6);
      end else begin
        chk("wr_no_we_cmd", {31'd0, o_reg_we}, 32'd0);
        idle(7);
      end
      for (int j = 0; j < int'(vecs[v].n); j++) begin
        drive_byte(vecs[v].din[j]);
        if (vecs[v].cmd[7]) begin
          chk("rd_re", {31'd0, o_reg_re}, 32'd1);
          chk("rd_addr", {25'd0, o_reg_addr}, {25'd0, vecs[v].addr[j+1]});
          tick();
          chk("rd_txdv", {31'd0, o_tx_dv}, 32'd1);
          chk("rd_txdata", {24'd0, o_tx_data}, {24'd0, vecs[v].dexp[j+1]});
          idle(6);
        end else begin
          chk("wr_we", {31'd0, o_reg_we}, {31'd0, vecs[v].wexp[j]});
          if (vecs[v].wexp[j]) begin
            chk("wr_addr", {25'd0, o_reg_addr}, {25'd0, vecs[v].addr[j]});
            chk("wr_data", {24'd0, o_reg_wdata}, {24'd0, vecs[v].din[j]});
          end
          idle(7);
        end
      end
      chk("frame_err", {31'd0, o_err}, {31'd0, vecs[v].err});
      i_ss = 1'b1;
      #1;
      chk("busy_after_ss", {31'd0, o_busy}, 32'd0);
      tick();
      if (vecs[v].err) begin
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        chk("err_cleared", {31'd0, o_err}, 32'd0);
      end
    end

    // Abort mid-write, then the next frame's first byte must be a command
    i_ss = 1'b0;
    idle(2);
    drive_byte(8'h30);
    idle(7);
    drive_byte(8'h44);
    chk("abort_we", {31'd0, o_reg_we}, 32'd1);
    chk("abort_addr", {25'd0, o_reg_addr}, 32'h30);
    idle(3);
    i_ss = 1'b1;
    #1;
    chk("abort_busy", {31'd0, o_busy}, 32'd0);
    tick();
    i_ss = 1'b0;
    idle(2);
    drive_byte(8'h85);
    chk("abort_new_cmd_re", {31'd0, o_reg_re}, 32'd1);
    chk("abort_new_cmd_addr", {25'd0, o_reg_addr}, 32'h05);
    chk("abort_no_we", {31'd0, o_reg_we}, 32'd0);
    idle(7);
    i_ss = 1'b1;
    tick();

    // Bytes landing in FETCH/LOAD are dropped; set beats a coincident clear
    i_ss = 1'b0;
    idle(2);
    drive_byte(8'hA0);
    chk("drop_err_before", {31'd0, o_err}, 32'd0);
    drive_byte(8'h00);
    chk("drop_txdv", {31'd0, o_tx_dv}, 32'd1);
    chk("drop_txdata", {24'd0, o_tx_data}, 32'h5A);
    chk("drop_err_set", {31'd0, o_err}, 32'd1);
    i_err_clr = 1'b1;
    drive_byte(8'h00);
    i_err_clr = 1'b0;
    chk("set_wins", {31'd0, o_err}, 32'd1);
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    chk("clr_alone", {31'd0, o_err}, 32'd0);
    chk("drop_no_refetch", {31'd0, o_reg_re}, 32'd0);
    idle(4);
    i_ss = 1'b1;
    tick();

    // Reset asserted while in S_RD_LOAD
    i_ss = 1'b0;
    idle(2);
    drive_byte(8'hA1);
    chk("rstrd_re", {31'd0, o_reg_re}, 32'd1);
    @(posedge S_CLK);
    #1;
    reset = 1'b0;
    #1;
    chk("rstrd_txdv", {31'd0, o_tx_dv}, 32'd0);
    chk("rstrd_txdata", {24'd0, o_tx_data}, 32'h00);
    chk("rstrd_addr", {25'd0, o_reg_addr}, 32'h00);
    chk("rstrd_busy_err", {30'd0, o_busy, o_err}, 32'd0);
    chk("rstrd_we_re", {30'd0, o_reg_we, o_reg_re}, 32'd0);
    tick();
    chk("rstrd_txdv_later", {31'd0, o_tx_dv}, 32'd0);
    reset = 1'b1;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
